vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 33 +++
 rtl/pclk_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants shared by the VGA timing slice
//
// Purpose: default divider/timing parameters, the derived line/frame totals
// and sync window bounds, and a window-membership helper.
// Ports: none (package).
package vga_pkg;

  localparam int DEF_CLK_DIV   = 4;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // lo <= x < hi, evaluated in 11 bits so an upper bound of 1024 still works
  // for a 10-bit counter.
  function automatic logic in_window(input logic [9:0] x, input int lo, input int hi);
    return ({1'b0, x} >= 11'(lo)) && ({1'b0, x} < 11'(hi));
  endfunction

endpackage

// File: rtl/pclk_div.sv
// rtl/pclk_div.sv - pixel-tick divider, one tick every CLK_DIV enabled clocks
//
// Purpose: free-running 0..CLK_DIV-1 counter that holds while en is low.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (counter to 0)
//   en    in  count enable; low holds the current count
//   tick  out high for the whole cycle in which the count is CLK_DIV-1
module pclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= (div_q == LAST) ? '0 : div_q + DW'(1);
    end
  end

  // Decoded from the held count, so it stays put while en is low and the
  // first enabled edge after resume continues exactly where counting stopped.
  assign tick = (div_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, pulses)
//
// Purpose: divides clk into pixel ticks and walks (h_cnt, v_cnt) across the
// raster, producing registered syncs, visible-area flag and line/frame pulses.
// Optional feature macro: VGA_FRAME_CNT_EN (enables the frame counter).
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   en          in  run enable; low freezes divider, counters and outputs
//   pclk_en     out one-clk pixel tick
//   h_cnt       out current column 0..H_TOTAL-1
//   v_cnt       out current row 0..V_TOTAL-1
//   hsync       out horizontal sync, active low
//   vsync       out vertical sync, active low
//   valid       out high inside the visible area
//   line_start  out one-clk pulse when h_cnt becomes 0
//   frame_start out one-clk pulse when (h_cnt, v_cnt) becomes (0, 0)
//   frame_cnt   out frames completed since reset (0 without VGA_FRAME_CNT_EN)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pclk_en,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_VISIBLE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);

  logic       tick;
  logic       advance;
  logic       h_wrap;
  logic       f_wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  pclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pclk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign pclk_en = tick;
  assign advance = en & tick;
  assign h_wrap  = (h_cnt == H_LAST);
  assign f_wrap  = h_wrap && (v_cnt == V_LAST);

  always_comb begin
    h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Syncs/valid are computed from the next counter values and registered
  // alongside the counters, so they always describe the current h_cnt/v_cnt.
  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (advance) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        hsync       <= !in_window(h_nxt, HS_LO, HS_HI);
        vsync       <= !in_window(v_nxt, VS_LO, VS_HI);
        valid       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_start  <= h_wrap;
        frame_start <= f_wrap;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // The first wrap after reset opens frame 0 rather than completing one.
  logic        seen_first;
  logic [15:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_first <= 1'b0;
      frame_q    <= 16'd0;
    end else if (advance && f_wrap) begin
      seen_first <= 1'b1;
      if (seen_first) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Small raster for frame-level scenarios: 25 x 12 pixels, 3 clk per tick.
  localparam int S_DIV = 3;
  localparam int S_HV = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VV = 6,  S_VFP = 2, S_VS = 2, S_VBP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic       pe_a, hs_a, vs_a, val_a, ls_a, fs_a;
  logic [9:0] h_a, v_a;
  logic [15:0] fc_a;
  logic       pe_b, hs_b, vs_b, val_b, ls_b, fs_b;
  logic [9:0] h_b, v_b;
  logic [15:0] fc_b;

  int checks = 0;
  int failures = 0;

  initial forever #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pclk_en(pe_a), .h_cnt(h_a), .v_cnt(v_a),
    .hsync(hs_a), .vsync(vs_a), .valid(val_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(S_DIV), .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pclk_en(pe_b), .h_cnt(h_b), .v_cnt(v_b),
    .hsync(hs_b), .vsync(vs_b), .valid(val_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // Reference: number of enabled clk edges since reset; everything else is
  // derived arithmetically from that count.
  longint ecyc;
  bit     last_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecyc    <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= en;
      if (en) ecyc <= ecyc + 1;
    end
  end

  typedef struct {
    int h; int v; bit hs; bit vs; bit val; bit pe; bit ls; bit fs; int fc;
  } exp_t;

  function automatic exp_t model(longint e, bit le, int d, int hv, int hfp, int hsw, int hbp,
                                 int vv, int vfp, int vsw, int vbp);
    exp_t r;
    int ht = hv + hfp + hsw + hbp;
    int vt = vv + vfp + vsw + vbp;
    longint n = e / d;
    longint p;
    if (n == 0) begin
      r.h = ht - 1;
      r.v = vt - 1;
    end else begin
      p   = (n - 1) % (ht * vt);
      r.h = int'(p % ht);
      r.v = int'(p / ht);
    end
    r.pe  = (e % d) == d - 1;
    r.hs  = !(r.h >= hv + hfp && r.h < hv + hfp + hsw);
    r.vs  = !(r.v >= vv + vfp && r.v < vv + vfp + vsw);
    r.val = r.h < hv && r.v < vv;
    r.ls  = le && n > 0 && (e % d) == 0 && r.h == 0;
    r.fs  = r.ls && r.v == 0;
`ifdef VGA_FRAME_CNT_EN
    r.fc  = (n == 0) ? 0 : int'(((n - 1) / (ht * vt)) % 65536);
`else
    r.fc  = 0;
`endif
    return r;
  endfunction

  function automatic exp_t exp_a();
    return model(ecyc, last_en, DEF_CLK_DIV, DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                 DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  endfunction

  function automatic exp_t exp_b();
    return model(ecyc, last_en, S_DIV, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (h_a !== 10'd799) begin failures++; $display("FAIL reset_h got=%0d want=799", h_a); end
    checks++; if (v_a !== 10'd524) begin failures++; $display("FAIL reset_v got=%0d want=524", v_a); end
    checks++; if ({hs_a, vs_a} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b want=11", {hs_a, vs_a}); end
    checks++; if ({val_a, pe_a, ls_a, fs_a} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {val_a, pe_a, ls_a, fs_a}); end
    checks++; if (fc_a !== 16'd0) begin failures++; $display("FAIL reset_fc got=%0d want=0", fc_a); end
    checks++; if ({h_b, v_b} !== {10'd24, 10'd11}) begin failures++; $display("FAIL reset_small_hv got=%0d,%0d want=24,11", h_b, v_b); end
  endtask

  // Called at a negedge with rst_n low; releases reset and walks to the first tick.
  task automatic test_first_tick(input string tag);
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (pe_a !== (k == 4)) begin failures++; $display("FAIL %s_pclk_en clk%0d got=%b want=%b", tag, k, pe_a, (k == 4)); end
      step();
    end
    checks++; if ({h_a, v_a} !== 20'd0) begin failures++; $display("FAIL %s_hv0 got=%0d,%0d want=0,0", tag, h_a, v_a); end
    checks++; if ({fs_a, ls_a, val_a} !== 3'b111) begin failures++; $display("FAIL %s_pulses got=%b want=111", tag, {fs_a, ls_a, val_a}); end
    step();
    checks++; if ({fs_a, ls_a, h_a} !== {2'b00, 10'd0}) begin failures++; $display("FAIL %s_pulse_once got=%b,%b,h=%0d want=0,0,h=0", tag, fs_a, ls_a, h_a); end
  endtask

  task automatic test_line();
    int hs_low = 0, ticks = 0, h_hs = -1, h_val = -1;
    for (int c = 0; c < 3200; c++) begin
      if (!hs_a) begin
        hs_low++;
        if (h_hs < 0) h_hs = h_a;
      end
      if (!val_a && h_val < 0) h_val = h_a;
      if (pe_a) ticks++;
      step();
    end
    checks++; if (hs_low != 384) begin failures++; $display("FAIL line_hsync_clk got=%0d want=384", hs_low); end
    checks++; if (h_hs != 656) begin failures++; $display("FAIL line_hsync_start got=%0d want=656", h_hs); end
    checks++; if (h_val != 640) begin failures++; $display("FAIL line_valid_end got=%0d want=640", h_val); end
    checks++; if (ticks != 800) begin failures++; $display("FAIL line_ticks got=%0d want=800", ticks); end
  endtask

  task automatic test_freeze();
    exp_t e;
    int guard = 0;
    while (!((ecyc % 4) == 2 && exp_a().h == 100) && guard < 5000) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 5000) begin failures++; $display("FAIL freeze_reach got=timeout want=div2_h100"); end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      e = exp_a();
      checks++;
      if ({h_a, pe_a, ls_a, fs_a, hs_a, vs_a, val_a} !== {10'd100, 3'b000, e.hs, e.vs, e.val}) begin
        failures++;
        $display("FAIL freeze_hold c%0d got=h%0d,%b want=h100,000%b%b%b", c, h_a,
                 {pe_a, ls_a, fs_a, hs_a, vs_a, val_a}, e.hs, e.vs, e.val);
      end
    end
    en = 1'b1;
    step();
    checks++; if ({pe_a, h_a} !== {1'b1, 10'd100}) begin failures++; $display("FAIL freeze_resume_tick got=%b,h%0d want=1,h100", pe_a, h_a); end
    step();
    checks++; if ({pe_a, h_a} !== {1'b0, 10'd101}) begin failures++; $display("FAIL freeze_resume_h got=%b,h%0d want=0,h101", pe_a, h_a); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 1500; c++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({h_a, v_a, hs_a, vs_a, val_a, pe_a, ls_a, fs_a, fc_a} !== {10'd799, 10'd524, 6'b110000, 16'd0}) begin
      failures++;
      $display("FAIL midreset_a got=h%0d v%0d %b fc%0d want=h799 v524 110000 fc0", h_a, v_a,
               {hs_a, vs_a, val_a, pe_a, ls_a, fs_a}, fc_a);
    end
    checks++;
    if ({h_b, v_b, pe_b, val_b} !== {10'd24, 10'd11, 2'b00}) begin
      failures++;
      $display("FAIL midreset_b got=h%0d v%0d pe%b val%b want=h24 v11 pe0 val0", h_b, v_b, pe_b, val_b);
    end
    step();
    test_first_tick("after_midreset");
  endtask

  task automatic test_frames();
    int gap, lines, vlow, bad_v;
    for (int f = 0; f < 3; f++) begin
      gap = 0; lines = 0; vlow = 0; bad_v = 0;
      do begin
        step();
        gap++;
        if (ls_b) lines++;
        if (!vs_b) begin
          vlow++;
          if (v_b < 10'd8 || v_b > 10'd9) bad_v++;
        end
      end while (!fs_b && gap < 2000);
      checks++;
      if (!fs_b) begin failures++; $display("FAIL frame_wait f%0d got=timeout want=frame_start", f); end
      if (f > 0) begin
        checks++; if (gap != 900) begin failures++; $display("FAIL frame_gap f%0d got=%0d want=900", f, gap); end
        checks++; if (lines != 12) begin failures++; $display("FAIL frame_lines f%0d got=%0d want=12", f, lines); end
        checks++; if (vlow != 150 || bad_v != 0) begin failures++; $display("FAIL frame_vsync f%0d got=%0d,bad%0d want=150,bad0", f, vlow, bad_v); end
      end
    end
    checks++;
`ifdef VGA_FRAME_CNT_EN
    if (fc_b !== 16'd3) begin failures++; $display("FAIL frame_cnt got=%0d want=3", fc_b); end
`else
    if (fc_b !== 16'd0) begin failures++; $display("FAIL frame_cnt got=%0d want=0", fc_b); end
`endif
  endtask

  task automatic test_random();
    exp_t ea, eb;
    logic [41:0] got, want;
    for (int c = 0; c < 20000; c++) begin
      ea = exp_a();
      eb = exp_b();
      got  = {h_a, v_a, hs_a, vs_a, val_a, pe_a, ls_a, fs_a, fc_a};
      want = {10'(ea.h), 10'(ea.v), ea.hs, ea.vs, ea.val, ea.pe, ea.ls, ea.fs, 16'(ea.fc)};
      checks++;
      if (got !== want) begin failures++; $display("FAIL random_a c%0d got=%h want=%h", c, got, want); end
      got  = {h_b, v_b, hs_b, vs_b, val_b, pe_b, ls_b, fs_b, fc_b};
      want = {10'(eb.h), 10'(eb.v), eb.hs, eb.vs, eb.val, eb.pe, eb.ls, eb.fs, 16'(eb.fc)};
      checks++;
      if (got !== want) begin failures++; $display("FAIL random_b c%0d got=%h want=%h", c, got, want); end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 6999) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_first_tick("first");
    test_line();
    test_freeze();
    test_reset_mid();
    test_frames();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
